// File: rtl/conv_mac.sv
// Serial signed dot-product engine: snapshots one window and kernel, then accumulates one tap per cycle.
// Define CONV_MAC_SAT_EN to clamp the final sum to the signed WIDTH range before it is presented.
module conv_mac #(
  parameter int LEN   = 8,
  parameter int WIDTH = 16,
  parameter int ACC_W = 2*WIDTH + $clog2(LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN*WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN*WIDTH-1:0]   kernel,
  output logic [ACC_W-1:0]       result,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [LEN*WIDTH-1:0]     r_win;
  logic [LEN*WIDTH-1:0]     r_ker;
  logic signed [ACC_W-1:0]  r_acc;
  logic [IDX_W-1:0]         r_idx;

  logic signed [WIDTH-1:0]   w_winTap;
  logic signed [WIDTH-1:0]   w_kerTap;
  logic signed [2*WIDTH-1:0] w_winExt;
  logic signed [2*WIDTH-1:0] w_kerExt;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prodExt;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_final;

  // Operands are widened to 2*WIDTH first so the product is the exact signed result.
  assign w_winTap  = r_win[r_idx*WIDTH +: WIDTH];
  assign w_kerTap  = r_ker[r_idx*WIDTH +: WIDTH];
  assign w_winExt  = {{WIDTH{w_winTap[WIDTH-1]}}, w_winTap};
  assign w_kerExt  = {{WIDTH{w_kerTap[WIDTH-1]}}, w_kerTap};
  assign w_prod    = w_winExt * w_kerExt;
  assign w_prodExt = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  assign w_sum     = r_acc + w_prodExt;

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_final = w_sum;
    if (w_sum > SAT_MAX) begin
      w_final = SAT_MAX;
    end else if (w_sum < SAT_MIN) begin
      w_final = SAT_MIN;
    end
  end
`else
  assign w_final = w_sum;
`endif

  // Gated by rst so nothing upstream sees a ready while the block is held in reset.
  assign in_ready = (r_state == IDLE) && !rst;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (in_valid) w_nextState = MAC;
      MAC:  if (r_idx == LAST_IDX) w_nextState = OUT;
      OUT:  if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_win     <= '0;
      r_ker     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_win <= in_data;
            r_ker <= kernel;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          if (r_idx == LAST_IDX) begin
            r_idx     <= '0;
            result    <= w_final;
            out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: directed windows plus random windows against an arithmetic dot-product model.
// Expectations follow CONV_MAC_SAT_EN when the bench is built with it.
module tb_conv_mac;

  localparam int LEN   = 8;
  localparam int WIDTH = 16;
  localparam int ACC_W = 35;
  localparam int VW    = LEN*WIDTH;

  logic              clk;
  logic              rst;
  logic [VW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [VW-1:0]     kernel;
  logic [ACC_W-1:0]  result;
  logic              out_valid;
  logic              out_ready;

  int nCompared;
  int nMismatched;

  int               accQ[$];
  logic [ACC_W-1:0] resQ[$];

  conv_mac #(.LEN(LEN), .WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .kernel(kernel),
    .result(result),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer sum of signed tap products, optionally clamped.
  function automatic logic [ACC_W-1:0] model(input logic [VW-1:0] d, input logic [VW-1:0] k);
    longint s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    s = 0;
    for (int i = 0; i < LEN; i++) begin
      a = d[i*WIDTH +: WIDTH];
      b = k[i*WIDTH +: WIDTH];
      s += longint'($signed(a)) * longint'($signed(b));
    end
`ifdef CONV_MAC_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [VW-1:0] fill(input logic [WIDTH-1:0] x);
    logic [VW-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*WIDTH +: WIDTH] = x;
    return v;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*WIDTH +: WIDTH] = WIDTH'(i+1);
    return v;
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the accepting edge.
  task automatic applyStimulus(input logic [VW-1:0] d, input logic [VW-1:0] k);
    int n;
    in_data  = d;
    kernel   = k;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    checkOutput("out_valid_seen", 64'(out_valid), 64'(1));
  endtask

  task automatic checkWindow(input string tag, input logic [VW-1:0] d, input logic [VW-1:0] k,
                             input logic [ACC_W-1:0] expected, input int hold, input bit scramble);
    int lat;
    out_ready = (hold == 0);
    applyStimulus(d, k);
    if (scramble) begin
      in_data = randVec();
      kernel  = fill(16'd5);
    end
    waitOutput(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LEN));
    checkOutput({tag, "_result"}, 64'(result), 64'(expected));
    repeat (hold) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, "_hold_result"}, 64'(result), 64'(expected));
      checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [VW-1:0] wA, kA, wB, kB, d;
    logic [ACC_W-1:0] expA, expB, exp3;
    int lat;
    int nextWin;
    bit pending;

    nCompared   = 0;
    nMismatched = 0;
    rst       = 1'b1;
    in_data   = '0;
    kernel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Ramp data against unit kernel, single-cycle output
    checkWindow("ramp", ramp(), fill(16'd1), 35'd36, 0, 1'b0);

    // All -3 times all 2
    checkWindow("neg", fill(16'hFFFD), fill(16'd2), 35'h7_FFFF_FFD0, 0, 1'b0);

    // Most negative taps squared
`ifdef CONV_MAC_SAT_EN
    checkWindow("minneg", fill(16'h8000), fill(16'h8000), 35'd32767, 1, 1'b0);
`else
    checkWindow("minneg", fill(16'h8000), fill(16'h8000), 35'h2_0000_0000, 1, 1'b0);
`endif

    // Backpressure with a second window waiting
`ifdef CONV_MAC_SAT_EN
    exp3 = 35'd32767;
`else
    exp3 = 35'h1_FFF8_0008;
`endif
    out_ready = 1'b0;
    d = fill(16'h7FFF);
    applyStimulus(d, d);
    waitOutput(lat);
    checkOutput("bp_latency", 64'(lat), 64'(LEN));
    checkOutput("bp_result", 64'(result), 64'(exp3));
    in_data  = ramp();
    kernel   = fill(16'd1);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'(1));
      checkOutput("bp_hold_result", 64'(result), 64'(exp3));
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 64'(out_valid), 64'(0));
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_second_taken", 64'(in_ready), 64'(0));
    waitOutput(lat);
    checkOutput("bp_second_latency", 64'(lat), 64'(LEN));
    checkOutput("bp_second_result", 64'(result), 64'(36));
    @(negedge clk);
    checkOutput("bp_second_drop", 64'(out_valid), 64'(0));

    // Inputs change after acceptance; the snapshot must be used
    checkWindow("snapshot", ramp(), fill(16'd1), 35'd36, 0, 1'b1);

    // Reset in the middle of MAC
    out_ready = 1'b1;
    applyStimulus(ramp(), fill(16'd2));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_result", 64'(result), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_ready", 64'(in_ready), 64'(1));
    checkWindow("after_rst", ramp(), fill(16'd1), 35'd36, 0, 1'b0);

    // Random windows with random output backpressure
    for (int r = 0; r < 8; r++) begin
      wA = randVec();
      kA = randVec();
      checkWindow("random", wA, kA, model(wA, kA), int'($urandom_range(0, 3)), 1'(r % 2));
    end

    // Back-to-back with in_valid held high
    wA = randVec();
    kA = randVec();
    wB = randVec();
    kB = randVec();
    expA = model(wA, kA);
    expB = model(wB, kB);
    accQ.delete();
    resQ.delete();
    out_ready = 1'b1;
    in_data   = wA;
    kernel    = kA;
    in_valid  = 1'b1;
    nextWin   = 1;
    pending   = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (pending) begin
        if (nextWin == 1) begin
          in_data = wB;
          kernel  = kB;
          nextWin = 2;
        end else begin
          in_valid = 1'b0;
        end
        pending = 1'b0;
      end
      if (in_valid && in_ready) begin
        accQ.push_back(t);
        pending = 1'b1;
      end
      if (out_valid) resQ.push_back(result);
      @(negedge clk);
    end
    checkOutput("b2b_accept_count", 64'(accQ.size()), 64'(2));
    checkOutput("b2b_result_count", 64'(resQ.size()), 64'(2));
    if (accQ.size() >= 2) checkOutput("b2b_spacing", 64'(accQ[1] - accQ[0]), 64'(LEN + 2));
    if (resQ.size() >= 1) checkOutput("b2b_result_a", 64'(resQ[0]), 64'(expA));
    if (resQ.size() >= 2) checkOutput("b2b_result_b", 64'(resQ[1]), 64'(expB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
